pulse_window_counter: RTL
=========================

# pulse_window_counter

Downstream consumer of the one-cycle pulse/edge detector strobes. Counts `detected` strobes over fixed, back-to-back windows of `WINDOW` clock cycles and hands each window's total to the next stage. Output uses a valid/ready handshake with a one-entry output register. A window result that cannot be accepted is dropped and flagged.

## Interface
- `WINDOW`, 16: cycles per counting window; legal range ≥ 2.
- `CNT_W`, 8: width of the per-window count and output data.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state immediately.
- `pulse`  in  1  one-cycle strobe from the detector stage; sampled every cycle.
- `enable`  in  1  counting enable; low holds the window logic idle.
- `out_ready`  in  1  downstream accepts `out_count` when high together with `out_valid`.
- `out_valid`  out  1  output register holds an unconsumed window count.
- `out_count`  out  `CNT_W`  pulse total of the reported window.
- `out_overrun`  out  1  one-cycle strobe: a window closed while the output register was full and not draining; that result is lost.

## Operation
- State machine, two states:
  - IDLE: timer = 0, accumulator = 0.
  - COUNT: the window is running.
- IDLE→COUNT on the first cycle `enable`=1. That cycle is window cycle 0, and `pulse` in that cycle is counted.
- COUNT→IDLE on any cycle `enable`=0:
  - The partial window is discarded; timer and accumulator return to 0.
  - The output register, `out_valid` and `out_count` are untouched; a pending result still drains.
  - A `pulse` in that cycle is ignored.
- In COUNT, each cycle: timer increments and the accumulator adds `pulse`.
- Window close is the cycle with timer = `WINDOW`-1:
  - The closing total is accumulator + `pulse` of that same cycle.
  - The timer wraps to 0 and the accumulator restarts at 0, so the next window begins with no gap.
- Load rule at window close:
  - Load the closing total if `out_valid`=0, or if `out_valid`=1 and `out_ready`=1 in the same cycle. The simultaneous drain-and-load is legal and produces no overrun.
  - Otherwise keep the old contents and pulse `out_overrun` high for one cycle.
- Handshake rules:
  - A transfer occurs on a cycle with `out_valid`=1 and `out_ready`=1.
  - `out_valid` falls on the next cycle unless a new load happens on the transfer cycle.
  - `out_count` is stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` does not depend combinationally on `out_ready`.
- Arithmetic:
  - The accumulator is `CNT_W` bits wide.
  - Overflow behaviour is set by the configuration macro (see Configuration).
  - The timer is `$clog2(WINDOW)` bits and counts 0..`WINDOW`-1 only.

## Timing
- Reset values: `out_valid`=0, `out_count`=0, `out_overrun`=0; state IDLE; timer and accumulator 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: window close at cycle t gives `out_valid`=1 and the new `out_count` at cycle t+1.
- Latency: `out_overrun` from a close at cycle t is high during cycle t+1 only.
- Throughput: one result per `WINDOW` cycles when `out_ready` is held high.
- `rst` asserted mid-window or mid-handshake:
  - Outputs clear without waiting for a clock edge; any pending result is lost.
  - After release, the first enabled cycle is window cycle 0.

## Configuration
- `PULSE_WINDOW_SATURATE_EN` defined: the accumulator saturates at 2^`CNT_W`-1; further pulses in that window are ignored.
- `PULSE_WINDOW_SATURATE_EN` undefined: the accumulator wraps modulo 2^`CNT_W`.

## Test plan
All scenarios use `WINDOW`=4, `CNT_W`=3 unless noted; cycle 0 is the first cycle with `enable`=1.
- Reset: assert `rst` with no clock edge → `out_valid`=0, `out_count`=0, `out_overrun`=0 immediately. Assert `rst` mid-window → same, and the next window starts at cycle 0 after release.
- Basic count: `out_ready`=1, `pulse` high at cycles 0 and 2 → `out_valid`=1 with `out_count`=2 at cycle 4 only; next window with pulse at cycle 7 (last window cycle) → `out_count`=1 at cycle 8.
- Backpressure/overrun: `out_ready`=0; window 1 has 1 pulse, window 2 has 3 pulses → `out_count`=1 held from cycle 4; `out_overrun`=1 at cycle 8 only; `out_count` still 1.
- Simultaneous drain and load: `out_valid`=1 holding 1 pulse, `out_ready`=1 exactly on the closing cycle of a 2-pulse window → next cycle `out_valid`=1, `out_count`=2, `out_overrun`=0.
- Enable drop: pulses at cycles 0 and 1, `enable`=0 at cycle 2, `enable`=1 again at cycle 5 with no pulses → no result from the partial window; the new window reports `out_count`=0.
- Overflow: `WINDOW`=12, `pulse` high every cycle → `out_count`=7 with the macro defined; `out_count`=4 (12 mod 8) without it.

Source files
------------

// File: rtl/pulse_window_counter_if.sv
// Result channel of pulse_window_counter: one window total per valid/ready transfer.
// Ports: valid/count/overrun driven by the counter (master); ready driven by the consumer (slave).
// CNT_W sets the width of count and must match the counter instance it is bound to.
interface pulse_window_counter_if #(
    parameter int CNT_W = 8
);
    logic             valid;
    logic             ready;
    logic [CNT_W-1:0] count;
    logic             overrun;

    modport master (output valid, output count, output overrun, input ready);
    modport slave  (input valid, input count, input overrun, output ready);
endinterface

// File: rtl/pulse_window_counter.sv
// Counts single-cycle pulse strobes over back-to-back WINDOW-cycle windows and
// presents each window total through a one-entry valid/ready output register.
// Ports: clk, rst (async, active-high), pulse, enable; out = result channel
// (valid, count, overrun out; ready in). Result appears the cycle after window close.
// A close that finds the register full and not draining drops its result and
// strobes overrun for one cycle. Optional macro PULSE_WINDOW_SATURATE_EN makes
// the accumulator saturate instead of wrapping.
module pulse_window_counter #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pulse,
    input  logic                     enable,
    pulse_window_counter_if.master   out
);
    localparam int             TW   = $clog2(WINDOW);
    localparam logic [TW-1:0]  LAST = TW'(WINDOW - 1);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state, state_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [CNT_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] sum;
    logic             close;
    logic             load;

    // Running total including this cycle's pulse.
    always_comb begin
`ifdef PULSE_WINDOW_SATURATE_EN
        sum = (pulse && (acc != {CNT_W{1'b1}})) ? acc + CNT_W'(1) : acc;
`else
        sum = acc + CNT_W'(pulse);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            acc   <= acc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        acc_nxt   = acc;
        close     = 1'b0;
        case (state)
            IDLE: begin
                // Timer and accumulator are already zero here, so the first
                // enabled cycle is window cycle 0 and its pulse is counted.
                // WINDOW >= 2 means cycle 0 can never be the closing cycle.
                if (enable) begin
                    state_nxt = COUNT;
                    timer_nxt = TW'(1);
                    acc_nxt   = sum;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                    acc_nxt   = '0;
                end else if (timer == LAST) begin
                    // Wrap without a gap: next cycle is cycle 0 of a new window.
                    close     = 1'b1;
                    timer_nxt = '0;
                    acc_nxt   = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                    acc_nxt   = sum;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
                acc_nxt   = '0;
            end
        endcase
    end

    // A drain on the closing cycle frees the register in time for the new total.
    assign load = close && (!out.valid || out.ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out.valid   <= 1'b0;
            out.count   <= '0;
            out.overrun <= 1'b0;
        end else begin
            out.overrun <= close && !load;
            if (load) begin
                out.valid <= 1'b1;
                out.count <= sum;
            end else if (out.ready) begin
                out.valid <= 1'b0;
            end
        end
    end
endmodule
